// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and constants for the serial adder responder
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } adder_state_e;

  localparam int ADDER_WIDTH = 8;
  localparam int OP_COUNT_W  = 16;

endpackage

// File: rtl/adder_serial_rsp_if.sv
// rtl/adder_serial_rsp_if.sv - operand request / result response channels of the adder
interface adder_serial_rsp_if #(
  parameter int WIDTH = adder_pkg::ADDER_WIDTH
) ();

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;

  modport master (
    output req_valid, a, b, rsp_ready,
    input  req_ready, rsp_valid, sum, carry
  );

  modport slave (
    input  req_valid, a, b, rsp_ready,
    output req_ready, rsp_valid, sum, carry
  );

endinterface

// File: rtl/adder_slice.sv
// rtl/adder_slice.sv - combinational W-bit adder slice with carry in and carry out
module adder_slice #(
  parameter int W = 1
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};

endmodule

// File: rtl/adder_serial_rsp.sv
// rtl/adder_serial_rsp.sv - serial a+b responder, BITS_PER_CYCLE bits per clock, valid/ready both sides
module adder_serial_rsp
  import adder_pkg::*;
#(
  parameter int WIDTH          = ADDER_WIDTH,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  adder_serial_rsp_if.slave     bus,
  output logic [OP_COUNT_W-1:0] op_count
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % BITS_PER_CYCLE) != 0 || BITS_PER_CYCLE < 1) begin : g_bad_cfg
    $error("adder_serial_rsp: BITS_PER_CYCLE must divide WIDTH");
  end

  adder_state_e          state_q;
  logic [WIDTH-1:0]      a_q, b_q, res_q, res_d, sum_q;
  logic                  cin_q, carry_q;
  logic [CNT_W-1:0]      k_q;
  logic                  req_ready_q, rsp_valid_q;
  logic [OP_COUNT_W-1:0] op_count_q;

  logic [BITS_PER_CYCLE-1:0] slice_a, slice_b, slice_sum;
  logic                      slice_cout;

  assign slice_a = a_q[int'(k_q) * BITS_PER_CYCLE +: BITS_PER_CYCLE];
  assign slice_b = b_q[int'(k_q) * BITS_PER_CYCLE +: BITS_PER_CYCLE];

  adder_slice #(.W(BITS_PER_CYCLE)) u_slice (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .cin_i  (cin_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  // Partial results build up in res_q so the visible sum only changes on the final slice.
  always_comb begin
    res_d = res_q;
    res_d[int'(k_q) * BITS_PER_CYCLE +: BITS_PER_CYCLE] = slice_sum;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      sum_q       <= '0;
      cin_q       <= 1'b0;
      carry_q     <= 1'b0;
      k_q         <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            a_q         <= bus.a;
            b_q         <= bus.b;
            cin_q       <= 1'b0;
            k_q         <= '0;
            req_ready_q <= 1'b0;
            state_q     <= CALC;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        CALC: begin
          res_q <= res_d;
          cin_q <= slice_cout;
          if (k_q == CNT_W'(N - 1)) begin
            sum_q       <= res_d;
            carry_q     <= slice_cout;
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        DONE: begin
          if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            op_count_q  <= op_count_q + 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          req_ready_q <= 1'b0;
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;
  assign op_count      = op_count_q;

endmodule

// File: tb/tb_adder_serial_rsp.sv
// tb/tb_adder_serial_rsp.sv - directed self-checking bench for adder_serial_rsp
module tb_adder_serial_rsp;

  logic        clk;
  logic        rstn;
  logic [15:0] op_count8, op_count4;
  int          n_checks = 0;
  int          n_errors = 0;

  adder_serial_rsp_if #(.WIDTH(8)) if8 ();
  adder_serial_rsp_if #(.WIDTH(8)) if4 ();

  adder_serial_rsp #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut1 (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (if8.slave),
    .op_count (op_count8)
  );

  adder_serial_rsp #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (if4.slave),
    .op_count (op_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [7:0] a, input logic [7:0] b, output int lat);
    int w;
    if8.a = a;
    if8.b = b;
    if8.req_valid = 1'b1;
    w = 0;
    while (if8.req_ready !== 1'b1 && w < 40) begin
      tick();
      w++;
    end
    check("req_accept", 32'(if8.req_ready), 32'd1);
    tick();
    if8.req_valid = 1'b0;
    check("req_ready_low_after_accept", 32'(if8.req_ready), 32'd0);
    lat = 0;
    while (if8.rsp_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic take_rsp();
    if8.rsp_ready = 1'b1;
    tick();
    if8.rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (3) begin
      tick();
      check("rst_req_ready", 32'(if8.req_ready), 32'd0);
      check("rst_rsp_valid", 32'(if8.rsp_valid), 32'd0);
      check("rst_sum", 32'(if8.sum), 32'd0);
      check("rst_carry", 32'(if8.carry), 32'd0);
      check("rst_op_count", 32'(op_count8), 32'd0);
    end
    @(negedge clk);
    rstn = 1'b1;
    tick();
    check("req_ready_after_release", 32'(if8.req_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int seen;
    rstn          = 1'b0;
    if8.req_valid = 1'b0;
    if8.rsp_ready = 1'b0;
    if8.a         = '0;
    if8.b         = '0;
    if4.req_valid = 1'b0;
    if4.rsp_ready = 1'b0;
    if4.a         = '0;
    if4.b         = '0;

    do_reset();

    // basic add
    send_req(8'h0F, 8'h01, lat);
    check("basic_latency", 32'(lat), 32'd8);
    check("basic_sum", 32'(if8.sum), 32'h10);
    check("basic_carry", 32'(if8.carry), 32'd0);
    take_rsp();
    check("basic_op_count", 32'(op_count8), 32'd1);
    check("basic_rsp_valid_drop", 32'(if8.rsp_valid), 32'd0);
    check("basic_req_ready_back", 32'(if8.req_ready), 32'd1);

    // overflow pair from a fresh reset
    do_reset();
    send_req(8'hFF, 8'h01, lat);
    check("ovf1_latency", 32'(lat), 32'd8);
    check("ovf1_sum", 32'(if8.sum), 32'h00);
    check("ovf1_carry", 32'(if8.carry), 32'd1);
    take_rsp();
    send_req(8'h80, 8'h80, lat);
    check("ovf2_sum", 32'(if8.sum), 32'h00);
    check("ovf2_carry", 32'(if8.carry), 32'd1);
    take_rsp();
    check("ovf_op_count", 32'(op_count8), 32'd2);

    // backpressure with a competing request held high
    send_req(8'h35, 8'h4A, lat);
    check("bp_latency", 32'(lat), 32'd8);
    if8.a = 8'h11;
    if8.b = 8'h22;
    if8.req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_sum_held", 32'(if8.sum), 32'h7F);
      check("bp_carry_held", 32'(if8.carry), 32'd0);
      check("bp_rsp_valid_held", 32'(if8.rsp_valid), 32'd1);
      check("bp_req_ready_low", 32'(if8.req_ready), 32'd0);
    end
    take_rsp();
    check("bp_op_count", 32'(op_count8), 32'd3);
    check("bp_req_ready_back", 32'(if8.req_ready), 32'd1);
    send_req(8'h11, 8'h22, lat);
    check("bp_next_latency", 32'(lat), 32'd8);
    check("bp_next_sum", 32'(if8.sum), 32'h33);
    take_rsp();

    // reset mid-CALC discards the operation
    do_reset();
    if8.a = 8'h12;
    if8.b = 8'h34;
    if8.req_valid = 1'b1;
    tick();
    if8.req_valid = 1'b0;
    check("midrst_accepted", 32'(if8.req_ready), 32'd0);
    repeat (4) tick();
    rstn = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (if8.rsp_valid === 1'b1) seen++;
    end
    check("midrst_no_rsp", 32'(seen), 32'd0);
    check("midrst_op_count", 32'(op_count8), 32'd0);

    // rsp_ready already high before rsp_valid
    if8.rsp_ready = 1'b1;
    send_req(8'h12, 8'h34, lat);
    check("early_ready_latency", 32'(lat), 32'd8);
    check("early_ready_sum", 32'(if8.sum), 32'h46);
    tick();
    if8.rsp_ready = 1'b0;
    check("early_ready_op_count", 32'(op_count8), 32'd1);
    check("early_ready_rsp_drop", 32'(if8.rsp_valid), 32'd0);

    // four bits per cycle
    if4.a = 8'hFF;
    if4.b = 8'hFF;
    if4.req_valid = 1'b1;
    seen = 0;
    while (if4.req_ready !== 1'b1 && seen < 40) begin
      tick();
      seen++;
    end
    check("bpc4_accept", 32'(if4.req_ready), 32'd1);
    tick();
    if4.req_valid = 1'b0;
    lat = 0;
    while (if4.rsp_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    check("bpc4_latency", 32'(lat), 32'd2);
    check("bpc4_sum", 32'(if4.sum), 32'hFE);
    check("bpc4_carry", 32'(if4.carry), 32'd1);
    if4.rsp_ready = 1'b1;
    tick();
    if4.rsp_ready = 1'b0;
    check("bpc4_op_count", 32'(op_count4), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
